// File: rtl/multicycle_cpu.sv
// multicycle_cpu: FSM-sequenced multi-cycle core (PC, regfile, decoder, ALU).
// Fetch and data accesses share one req/ack memory port, so RAM latency may vary.
// Ports:
//   clk, reset (async, active-high)
//   mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in
//   halted, illegal_op (sticky), flag_z, flag_c, pc_out (debug)
module multicycle_cpu #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              illegal_op,
  output logic              flag_z,
  output logic              flag_c,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int RA_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_LDI   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_BEQZ  = 4'hA;
  localparam logic [3:0] OP_BNEZ  = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_z;
  logic              r_c;
  logic              r_ill;
  logic              r_halt;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [3:0]        w_op;
  logic [RA_W-1:0]   w_rd;
  logic [RA_W-1:0]   w_rs;
  logic [ADDR_W-1:0] w_a;
  logic [DATA_W:0]   w_alu;
  logic              w_is_alu;
  logic              w_is_br;
  logic              w_taken;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_op     = r_ir[DATA_W-1 -: 4];
  assign w_rd     = r_ir[DATA_W-5 -: RA_W];
  assign w_rs     = r_ir[DATA_W-5-RA_W -: RA_W];
  assign w_a      = r_ir[ADDR_W-1:0];
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_is_alu = (w_op >= OP_ADD) && (w_op <= OP_XOR);
  assign w_is_br  = (w_op == OP_JMP) || (w_op == OP_BEQZ) ||
                    (w_op == OP_BNEZ);
  // Branches test the register value, never flag_z.
  assign w_taken  = (w_op == OP_JMP) ||
                    ((w_op == OP_BEQZ) && (r_a == '0)) ||
                    ((w_op == OP_BNEZ) && (r_a != '0));
  assign w_tgt    = w_taken ? w_a : r_pc;

  // Extra top bit carries ADD carry-out / SUB borrow.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = {1'b0, r_a} + {1'b0, r_b};
      OP_SUB:  w_alu = {1'b0, r_a} - {1'b0, r_b};
      OP_AND:  w_alu = {1'b0, r_a & r_b};
      OP_OR:   w_alu = {1'b0, r_a | r_b};
      OP_XOR:  w_alu = {1'b0, r_a ^ r_b};
      OP_LDI:  w_alu = (DATA_W+1)'(w_a);
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= PC0;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_ill   <= 1'b0;
      r_halt  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Only reached with req low straight after reset.
          if (!r_req) begin
            r_req  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= r_pc;
          end else if (mem_ack) begin
            r_ir    <= mem_rdata;
            r_pc    <= w_pc_inc;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a <= r_regs[w_rd];
          r_b <= r_regs[w_rs];
          case (w_op)
            OP_NOP: begin
              r_req   <= 1'b1;
              r_addr  <= r_pc;
              r_state <= S_FETCH;
            end
            OP_LOAD, OP_STORE: begin
              r_req   <= 1'b1;
              r_we    <= (w_op == OP_STORE);
              r_addr  <= w_a;
              r_wdata <= r_regs[w_rd];
              r_state <= S_MEM;
            end
            OP_HALT: begin
              r_halt  <= 1'b1;
              r_state <= S_HALT;
            end
            4'hC, 4'hD, 4'hE: begin
              r_ill   <= 1'b1;
              r_halt  <= 1'b1;
              r_state <= S_HALT;
            end
            default: r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          if (w_is_br) begin
            r_pc    <= w_tgt;
            r_addr  <= w_tgt;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            r_res <= w_alu[DATA_W-1:0];
            if (w_is_alu) begin
              r_z <= (w_alu[DATA_W-1:0] == '0);
              r_c <= w_alu[DATA_W];
            end
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            r_we <= 1'b0;
            if (r_we) begin
              // Store done: next request is the fetch.
              r_addr  <= r_pc;
              r_state <= S_FETCH;
            end else begin
              r_req   <= 1'b0;
              r_res   <= mem_rdata;
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_regs[w_rd] <= r_res;
          r_req        <= 1'b1;
          r_addr       <= r_pc;
          r_state      <= S_FETCH;
        end
        S_HALT: r_req <= 1'b0;
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign mem_req    = r_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign halted     = r_halt;
  assign illegal_op = r_ill;
  assign flag_z     = r_z;
  assign flag_c     = r_c;
  assign pc_out     = r_pc;

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed and randomized checks of multicycle_cpu
// against an instruction-level reference model with a wait-state memory.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, pc_out;
  logic [15:0] mem_wdata, mem_rdata;
  logic        halted, illegal_op, flag_z, flag_c;

  always #5 clk = ~clk;

  multicycle_cpu #(
    .DATA_W(16), .ADDR_W(8), .NUM_REGS(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .illegal_op(illegal_op),
    .flag_z(flag_z), .flag_c(flag_c), .pc_out(pc_out)
  );

  logic [15:0] mem [256];
  logic [15:0] prog [256];
  logic        tb_load = 1'b1;
  int          n_wait = 0;
  int          cnt = 0;
  int          cyc = 0;
  int          stab_err = 0;
  logic        pend = 1'b0;
  logic [7:0]  p_addr;
  logic        p_we;
  logic [15:0] p_wdata;
  int          log_addr[$], log_we[$], log_data[$], log_t[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  assign mem_ack   = mem_req && (cnt >= n_wait);
  assign mem_rdata = mem[mem_addr];

  // Memory responder: acks after n_wait un-acked request cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_load) for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    if (pend && mem_req &&
        (mem_addr !== p_addr || mem_we !== p_we ||
         mem_wdata !== p_wdata))
      stab_err <= stab_err + 1;
    pend    <= mem_req && !mem_ack && !reset;
    p_addr  <= mem_addr;
    p_we    <= mem_we;
    p_wdata <= mem_wdata;
    if (reset) cnt <= 0;
    else if (mem_req && mem_ack) begin
      cnt <= 0;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      log_addr.push_back(int'(mem_addr));
      log_we.push_back(int'(mem_we));
      log_data.push_back(int'(mem_wdata));
      log_t.push_back(cyc);
    end else if (mem_req) cnt <= cnt + 1;
    else cnt <= 0;
  end

  // Reference model: ISA interpreter plus per-instruction timing.
  logic [15:0] mm [256];
  logic [15:0] mr [4];
  logic        mz, mc, mill, mhalt;
  logic [7:0]  mpc;
  int          e_addr[$], e_we[$], e_data[$], e_t[$];

  function automatic logic [15:0] enc(input int op, input int rd,
                                      input int rs, input int a);
    return {4'(op), 2'(rd), 2'(rs), 8'(a)};
  endfunction

  task automatic model_run(input int nw);
    int t;
    logic [15:0] ir;
    logic [3:0] op;
    int rd, rs, s;
    logic [7:0] a;
    t = 0;
    e_addr.delete(); e_we.delete(); e_data.delete(); e_t.delete();
    mpc = 8'd0; mz = 0; mc = 0; mill = 0; mhalt = 0;
    for (int i = 0; i < 4; i++) mr[i] = 16'd0;
    for (int i = 0; i < 256; i++) mm[i] = prog[i];
    for (int k = 0; k < 400 && !mhalt; k++) begin
      e_addr.push_back(int'(mpc)); e_we.push_back(0);
      e_data.push_back(0); e_t.push_back(t);
      ir = mm[mpc];
      mpc = mpc + 8'd1;
      op = ir[15:12]; rd = int'(ir[11:10]);
      rs = int'(ir[9:8]); a = ir[7:0];
      case (op)
        4'h0: t += 2 + nw;
        4'h1: begin
          e_addr.push_back(int'(a)); e_we.push_back(0);
          e_data.push_back(0); e_t.push_back(t + 2 + nw);
          mr[rd] = mm[a];
          t += 4 + 2 * nw;
        end
        4'h2: begin
          e_addr.push_back(int'(a)); e_we.push_back(1);
          e_data.push_back(int'(mr[rd])); e_t.push_back(t + 2 + nw);
          mm[a] = mr[rd];
          t += 3 + 2 * nw;
        end
        4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
          if (op == 4'h3) begin
            s = int'(mr[rd]) + int'(mr[rs]);
            mc = (s > 65535);
          end else if (op == 4'h4) begin
            s = int'(mr[rd]) - int'(mr[rs]);
            mc = (mr[rd] < mr[rs]);
          end else begin
            if (op == 4'h5) s = int'(mr[rd] & mr[rs]);
            else if (op == 4'h6) s = int'(mr[rd] | mr[rs]);
            else s = int'(mr[rd] ^ mr[rs]);
            mc = 1'b0;
          end
          mr[rd] = 16'(s);
          mz = (mr[rd] == 16'd0);
          t += 4 + nw;
        end
        4'h8: begin mr[rd] = {8'h00, a}; t += 4 + nw; end
        4'h9: begin mpc = a; t += 3 + nw; end
        4'hA: begin if (mr[rd] == 0) mpc = a; t += 3 + nw; end
        4'hB: begin if (mr[rd] != 0) mpc = a; t += 3 + nw; end
        4'hF: mhalt = 1'b1;
        default: begin mill = 1'b1; mhalt = 1'b1; end
      endcase
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  task automatic run_prog(input int nw, output bit done);
    n_wait = nw;
    @(negedge clk);
    reset = 1'b1; tb_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tb_load = 1'b0;
    log_addr.delete(); log_we.delete();
    log_data.delete(); log_t.delete();
    reset = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (halted) begin done = 1'b1; break; end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({mem_req, mem_we, halted, illegal_op, flag_z, flag_c} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b want 000000",
               {mem_req, mem_we, halted, illegal_op, flag_z, flag_c});
    end
    tests_run++;
    if (pc_out !== 8'h00 || mem_addr !== 8'h00 || mem_wdata !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: pc=%h addr=%h wdata=%h want 0",
               pc_out, mem_addr, mem_wdata);
    end
    tb_load = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_fetch: req=%b addr=%h we=%b want 1 00 0",
               mem_req, mem_addr, mem_we);
    end
  endtask

  task automatic test_basic();
    bit done;
    clear_prog();
    prog[0] = enc(8, 0, 0, 5);
    prog[1] = enc(8, 1, 0, 3);
    prog[2] = enc(3, 0, 1, 0);
    prog[3] = enc(2, 0, 0, 8'h40);
    prog[4] = enc(15, 0, 0, 0);
    run_prog(0, done);
    tests_run++;
    if (!done || mem[8'h40] !== 16'd8 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_store: done=%0b m40=%h halted=%b want 1 0008 1",
               done, mem[8'h40], halted);
    end
    tests_run++;
    if (flag_z !== 1'b0 || flag_c !== 1'b0 || pc_out !== 8'h05) begin
      tests_failed++;
      $display("FAIL basic_flags: z=%b c=%b pc=%h want 0 0 05",
               flag_z, flag_c, pc_out);
    end
    tests_run++;
    if (log_t.size() != 6 ||
        log_t[1] - log_t[0] != 4 || log_t[3] - log_t[2] != 4 ||
        log_t[5] - log_t[3] != 3) begin
      tests_failed++;
      $display("FAIL basic_latency: n=%0d ldi=%0d add=%0d st=%0d want 6 4 4 3",
               log_t.size(), log_t[1] - log_t[0], log_t[3] - log_t[2],
               log_t[5] - log_t[3]);
    end
  endtask

  task automatic test_carry();
    bit done;
    clear_prog();
    prog[0] = enc(8, 0, 0, 8'hFF);
    prog[1] = enc(8, 1, 0, 8'hFF);
    for (int i = 2; i < 10; i++) prog[i] = enc(3, 0, 0, 0);
    prog[10] = enc(3, 0, 1, 0);
    prog[11] = enc(2, 0, 0, 8'h41);
    prog[12] = enc(3, 0, 1, 0);
    prog[13] = enc(2, 0, 0, 8'h42);
    prog[14] = enc(15, 0, 0, 0);
    run_prog(0, done);
    tests_run++;
    if (!done || mem[8'h41] !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL carry_ffff: done=%0b got %h want ffff",
               done, mem[8'h41]);
    end
    tests_run++;
    if (mem[8'h42] !== 16'h00FE || flag_c !== 1'b1 || flag_z !== 1'b0) begin
      tests_failed++;
      $display("FAIL carry_wrap: got %h c=%b z=%b want 00fe 1 0",
               mem[8'h42], flag_c, flag_z);
    end
  endtask

  task automatic test_sub_branch();
    bit done;
    clear_prog();
    prog[0] = enc(8, 0, 0, 7);
    prog[1] = enc(8, 1, 0, 7);
    prog[2] = enc(4, 0, 1, 0);
    prog[3] = enc(10, 0, 0, 8'h20);
    prog[8'h20] = enc(11, 0, 0, 8'h30);
    prog[8'h21] = enc(2, 0, 0, 8'h44);
    prog[8'h22] = enc(15, 0, 0, 0);
    prog[8'h44] = 16'hBEEF;
    run_prog(0, done);
    tests_run++;
    if (!done || flag_z !== 1'b1 || flag_c !== 1'b0 ||
        mem[8'h44] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL sub_equal: done=%0b z=%b c=%b m44=%h want 1 1 0 0000",
               done, flag_z, flag_c, mem[8'h44]);
    end
    tests_run++;
    if (log_addr.size() < 6 || log_addr[4] != 8'h20 ||
        log_addr[5] != 8'h21 || pc_out !== 8'h23) begin
      tests_failed++;
      $display("FAIL branch_path: a4=%h a5=%h pc=%h want 20 21 23",
               log_addr[4], log_addr[5], pc_out);
    end
  endtask

  task automatic test_wrap();
    bit done;
    int want[6];
    int bad;
    want = '{0, 1, 2, 8'hFF, 0, 8'h10};
    clear_prog();
    prog[0] = enc(11, 0, 0, 8'h10);
    prog[1] = enc(8, 0, 0, 1);
    prog[2] = enc(9, 0, 0, 8'hFF);
    prog[8'h10] = enc(15, 0, 0, 0);
    run_prog(0, done);
    bad = (log_addr.size() != 6) ? 1 : 0;
    for (int i = 0; i < 6 && i < log_addr.size(); i++)
      if (log_addr[i] != want[i]) bad++;
    tests_run++;
    if (!done || bad != 0 || pc_out !== 8'h11) begin
      tests_failed++;
      $display("FAIL pc_wrap: done=%0b bad=%0d n=%0d pc=%h want 1 0 6 11",
               done, bad, log_addr.size(), pc_out);
    end
  endtask

  task automatic test_wait();
    bit done;
    int s0;
    clear_prog();
    prog[0] = enc(8, 0, 0, 1);
    prog[1] = enc(8, 1, 0, 2);
    prog[2] = enc(3, 0, 1, 0);
    prog[3] = enc(2, 0, 0, 8'h45);
    prog[4] = enc(15, 0, 0, 0);
    s0 = stab_err;
    run_prog(3, done);
    tests_run++;
    if (!done || log_t.size() != 6 || log_t[3] - log_t[2] != 7) begin
      tests_failed++;
      $display("FAIL wait_add_lat: done=%0b n=%0d got %0d want 7",
               done, log_t.size(), log_t[3] - log_t[2]);
    end
    tests_run++;
    if (stab_err != s0 || mem[8'h45] !== 16'd3) begin
      tests_failed++;
      $display("FAIL wait_stable: unstable=%0d m45=%h want 0 0003",
               stab_err - s0, mem[8'h45]);
    end
    n_wait = 0;
  endtask

  task automatic test_illegal();
    bit done;
    clear_prog();
    prog[0] = enc(0, 0, 0, 0);
    prog[1] = enc(12, 0, 0, 0);
    prog[2] = enc(8, 0, 0, 9);
    run_prog(0, done);
    repeat (10) @(negedge clk);
    tests_run++;
    if (!done || illegal_op !== 1'b1 || halted !== 1'b1 || pc_out !== 8'h02) begin
      tests_failed++;
      $display("FAIL illegal_trap: done=%0b ill=%b halt=%b pc=%h want 1 1 1 02",
               done, illegal_op, halted, pc_out);
    end
    tests_run++;
    if (mem_req !== 1'b0 || log_addr.size() != 2) begin
      tests_failed++;
      $display("FAIL illegal_quiet: req=%b accesses=%0d want 0 2",
               mem_req, log_addr.size());
    end
  endtask

  task automatic test_reset_mid_load();
    bit done, seen;
    clear_prog();
    prog[0] = enc(1, 0, 0, 8'h50);
    prog[1] = enc(2, 0, 0, 8'h51);
    prog[2] = enc(15, 0, 0, 0);
    prog[8'h50] = 16'h1234;
    n_wait = 6;
    @(negedge clk);
    reset = 1'b1; tb_load = 1'b1;
    repeat (2) @(negedge clk);
    tb_load = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h50) begin seen = 1'b1; break; end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (!seen || mem_req !== 1'b0 || mem_addr !== 8'h00 || pc_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_load: seen=%0b req=%b addr=%h pc=%h want 1 0 00 00",
               seen, mem_req, mem_addr, pc_out);
    end
    run_prog(0, done);
    tests_run++;
    if (!done || mem[8'h51] !== 16'h1234 || flag_z !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_load: done=%0b m51=%h z=%b want 1 1234 0",
               done, mem[8'h51], flag_z);
    end
  endtask

  task automatic test_random();
    bit done;
    int nw, n, kind, tgt, bad, mbad, first;
    for (int it = 0; it < 20; it++) begin
      clear_prog();
      nw = $urandom_range(0, 2);
      n = $urandom_range(8, 30);
      for (int i = 8'h80; i < 8'h90; i++) prog[i] = 16'($urandom);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 9);
        tgt = $urandom_range(i + 1, n);
        case (kind)
          0: prog[i] = enc(0, 0, 0, 0);
          1: prog[i] = enc(1, $urandom_range(0, 3), 0, 8'h80 + $urandom_range(0, 15));
          2: prog[i] = enc(2, $urandom_range(0, 3), 0, 8'h90 + $urandom_range(0, 15));
          3, 4, 5: prog[i] = enc($urandom_range(3, 7), $urandom_range(0, 3),
                                 $urandom_range(0, 3), 0);
          6, 7: prog[i] = enc(8, $urandom_range(0, 3), 0, $urandom_range(0, 255));
          default: prog[i] = enc($urandom_range(9, 11), $urandom_range(0, 3), 0, tgt);
        endcase
      end
      for (int r = 0; r < 4; r++) prog[n + r] = enc(2, r, 0, 8'hF0 + r);
      prog[n + 4] = enc(15, 0, 0, 0);
      model_run(nw);
      run_prog(nw, done);
      bad = (log_addr.size() != e_addr.size()) ? 1 : 0;
      first = -1;
      for (int i = 0; i < e_addr.size() && i < log_addr.size(); i++) begin
        if (log_addr[i] != e_addr[i] || log_we[i] != e_we[i] ||
            (e_we[i] == 1 && log_data[i] != e_data[i]) ||
            (log_t[i] - log_t[0]) != e_t[i]) begin
          bad++;
          if (first < 0) first = i;
        end
      end
      tests_run++;
      if (!done || bad != 0) begin
        tests_failed++;
        $display("FAIL rand_trace[%0d]: done=%0b bad=%0d first=%0d n=%0d want n=%0d",
                 it, done, bad, first, log_addr.size(), e_addr.size());
      end
      mbad = 0;
      for (int i = 8'h80; i < 256; i++) if (mem[i] !== mm[i]) mbad++;
      tests_run++;
      if (mbad != 0 || {flag_z, flag_c} !== {mz, mc} || pc_out !== mpc ||
          illegal_op !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_state[%0d]: membad=%0d zc=%b%b pc=%h want 0 %b%b %h",
                 it, mbad, flag_z, flag_c, pc_out, mz, mc, mpc);
      end
    end
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_basic();
    test_carry();
    test_sub_branch();
    test_wrap();
    test_wait();
    test_illegal();
    test_reset_mid_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
